// File: rtl/mod_2011_pkg.sv
// Shared constants, chunk weight table and FSM state type for the mod-2011 residue blocks.
package mod_2011_pkg;

   localparam int unsigned MOD            = 2011;
   localparam int unsigned FOLD_K         = 37;
   localparam int unsigned IN_W           = 400;
   localparam int unsigned CHUNK_W        = 11;
   localparam int unsigned CHUNKS_PER_CYC = 4;
   localparam int unsigned N_CHUNKS       = 37;
   localparam int unsigned N_RUN          = 10;
   localparam int unsigned LAST_CNT       = N_RUN - 1;

   // W[i] = 2^(11*i) mod 2011, i.e. 37^i mod 2011.
   localparam logic [CHUNK_W-1:0] W [N_CHUNKS] = '{
      11'd1,    11'd37,   11'd1369, 11'd378,  11'd1920, 11'd655,  11'd103,  11'd1800,
      11'd237,  11'd725,  11'd682,  11'd1102, 11'd554,  11'd388,  11'd279,  11'd268,
      11'd1872, 11'd890,  11'd754,  11'd1755, 11'd583,  11'd1461, 11'd1771, 11'd1175,
      11'd1244, 11'd1786, 11'd1730, 11'd1669, 11'd1423, 11'd365,  11'd1439, 11'd957,
      11'd1222, 11'd972,  11'd1777, 11'd1397, 11'd1414
   };

   typedef enum logic [1:0] {StIdle, StRun, StFinal, StDone} state_e;

endpackage

// File: rtl/mod_2011_seq_reducer_if.sv
// Operand-in / residue-out handshake bundle for the sequential mod-2011 reducer.
interface mod_2011_seq_reducer_if;
   import mod_2011_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [IN_W:1]      X;
   logic               out_valid;
   logic               out_ready;
   logic [CHUNK_W-1:0] R;

   modport master (
      output in_valid, X, out_ready,
      input  in_ready, out_valid, R
   );

   modport slave (
      input  in_valid, X, out_ready,
      output in_ready, out_valid, R
   );

endinterface

// File: rtl/mod_2011_fold3.sv
// Combinational 25-bit to 12-bit fold using 2^11 = 37 (mod 2011); output < 2603.
module mod_2011_fold3
   import mod_2011_pkg::*;
(
   input  logic [24:0] s,
   output logic [11:0] f
);

   logic [19:0] f1;
   logic [14:0] f2;

   always_comb begin
      f1 = 20'(s[10:0])  + 20'(s[24:11])  * 20'(FOLD_K);
      f2 = 15'(f1[10:0]) + 15'(f1[19:11]) * 15'(FOLD_K);
      f  = 12'(f2[10:0]) + 12'(f2[14:11]) * 12'(FOLD_K);
   end

endmodule

// File: rtl/mod_2011_seq_reducer.sv
// Sequential X mod 2011 for a 400-bit operand: four weighted 11-bit chunks folded per cycle
// into a small accumulator over 10 cycles, then one conditional subtract.
module mod_2011_seq_reducer
   import mod_2011_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   abort,
   output logic                   busy,
   mod_2011_seq_reducer_if.slave  bus
);

   localparam int unsigned PAD_W = N_RUN * CHUNKS_PER_CYC * CHUNK_W;

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [11:0]        acc_q, acc_d;
   logic [IN_W:1]      op_q, op_d;
   logic [CHUNK_W-1:0] r_q, r_d;
   logic               out_valid_q, out_valid_d;

   logic [PAD_W-1:0]   x_pad;
   logic [24:0]        sum;
   logic [11:0]        fold_out;
   logic [5:0]         idx;
   logic [8:0]         pos;
   logic [CHUNK_W-1:0] chunk;
   logic [CHUNK_W-1:0] wt;

   // Zero padding makes the short top chunk and the unused slots of the last cycle read as 0.
   assign x_pad = PAD_W'(op_q);

   always_comb begin
      sum   = 25'(acc_q);
      idx   = '0;
      pos   = '0;
      chunk = '0;
      wt    = '0;
      for (int j = 0; j < int'(CHUNKS_PER_CYC); j++) begin
         idx   = 6'(cnt_q) * 6'(CHUNKS_PER_CYC) + 6'(j);
         pos   = 9'(idx) * 9'(CHUNK_W);
         chunk = x_pad[pos +: CHUNK_W];
         wt    = (idx < 6'(N_CHUNKS)) ? W[idx] : '0;
         sum   = sum + 25'(chunk) * 25'(wt);
      end
   end

   mod_2011_fold3 u_fold3 (
      .s (sum),
      .f (fold_out)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      op_d        = op_q;
      r_d         = r_q;
      out_valid_d = out_valid_q;
      if (abort) begin
         // R deliberately keeps its last value.
         state_d     = StIdle;
         cnt_d       = '0;
         acc_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  op_d    = bus.X;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = StRun;
               end
            end
            StRun: begin
               acc_d = fold_out;
               if (cnt_q == 4'(LAST_CNT)) begin
                  state_d = StFinal;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            StFinal: begin
               r_d         = (acc_q >= 12'(MOD)) ? CHUNK_W'(acc_q - 12'(MOD)) : CHUNK_W'(acc_q);
               out_valid_d = 1'b1;
               state_d     = StDone;
            end
            StDone: begin
               if (bus.out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         acc_q       <= '0;
         op_q        <= '0;
         r_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         op_q        <= op_d;
         r_q         <= r_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = out_valid_q;
   assign bus.R         = r_q;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_mod_2011_seq_reducer.sv
// Directed and streamed checks of the sequential mod-2011 reducer against a bit-serial model.
module tb_mod_2011_seq_reducer;
   import mod_2011_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic abort;
   logic busy;

   mod_2011_seq_reducer_if bus ();

   mod_2011_seq_reducer dut (
      .clk   (clk),
      .rst   (rst),
      .abort (abort),
      .busy  (busy),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int prev_r = 0;

   // MSB-first Horner evaluation of X mod 2011.
   function automatic int ref_mod(input logic [IN_W:1] x);
      int r;
      r = 0;
      for (int i = IN_W; i >= 1; i--) r = (r * 2 + int'(x[i])) % 2011;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends one operand from IDLE, waits (bounded) for the result, then completes the handshake.
   task automatic run_op(input logic [IN_W:1] x, output int r, output int lat, output bit ok);
      bus.in_valid = 1'b1;
      bus.X        = x;
      step();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         step();
         lat++;
      end
      ok = bus.out_valid;
      r  = int'(bus.R);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; abort = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.X = '0;
      #12;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (bus.R !== 11'd0) begin errors++; $display("FAIL reset_R got %0d want 0", bus.R); end
      @(negedge clk);
      rst = 1'b0;
      step();
   endtask

   task automatic test_latency();
      bus.in_valid = 1'b1;
      bus.X        = 400'd1;
      step();
      bus.in_valid = 1'b0;
      for (int c = 0; c <= 11; c++) begin
         if (c > 0) step();
         checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL lat_ready_busy c=%0d got %b/%b want 0/1", c, bus.in_ready, busy);
         end
         checks++; if (bus.out_valid !== 1'(c == 11)) begin
            errors++; $display("FAIL lat_out_valid c=%0d got %b want %b", c, bus.out_valid, c == 11);
         end
      end
      checks++; if (bus.R !== 11'd1) begin errors++; $display("FAIL lat_R got %0d want 1", bus.R); end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL lat_release got %b/%b want 0/1", bus.out_valid, bus.in_ready);
      end
      prev_r = 1;
   endtask

   task automatic test_vectors();
      logic [IN_W:1] xs [8];
      int exp_r [8];
      int r, lat;
      bit ok;
      xs[0] = 400'd2011; exp_r[0] = 0;
      xs[1] = '0; xs[1][12]  = 1'b1; exp_r[1] = 37;
      xs[2] = '0; xs[2][23]  = 1'b1; exp_r[2] = 1369;
      xs[3] = '0; xs[3][397] = 1'b1; exp_r[3] = 1414;
      xs[4] = 400'd2010; exp_r[4] = 2010;
      xs[5] = 400'd4022; exp_r[5] = 0;
      xs[6] = 400'd2047; exp_r[6] = 36;
      xs[7] = '1;        exp_r[7] = ref_mod(xs[7]);
      for (int i = 0; i < 8; i++) begin
         run_op(xs[i], r, lat, ok);
         checks++; if (!ok) begin errors++; $display("FAIL vec%0d_timeout got none want out_valid", i); end
         checks++; if (r != exp_r[i]) begin errors++; $display("FAIL vec%0d_R got %0d want %0d", i, r, exp_r[i]); end
         checks++; if (lat != 11) begin errors++; $display("FAIL vec%0d_latency got %0d want 11", i, lat); end
      end
      prev_r = exp_r[7];
   endtask

   task automatic test_backpressure();
      int n;
      bus.in_valid = 1'b1;
      bus.X        = 400'd2053;  // 2^11 + 5 -> 42
      step();
      bus.in_valid = 1'b0;
      bus.X        = '1;
      n = 0;
      while (!bus.out_valid && n < 40) begin step(); n++; end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got %b want 1", bus.out_valid); end
      for (int c = 0; c < 5; c++) begin
         checks++; if (bus.out_valid !== 1'b1 || bus.R !== 11'd42 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold c=%0d got v=%b R=%0d rdy=%b want 1/42/0", c, bus.out_valid, bus.R, bus.in_ready);
         end
         step();
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.X         = 400'd4030;
      step();
      bus.out_ready = 1'b0;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL bp_handshake got v=%b rdy=%b busy=%b want 0/1/0", bus.out_valid, bus.in_ready, busy);
      end
      step();
      bus.in_valid = 1'b0;
      checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_reaccept got busy=%b rdy=%b want 1/0", busy, bus.in_ready);
      end
      n = 0;
      while (!bus.out_valid && n < 40) begin step(); n++; end
      checks++; if (n != 11) begin errors++; $display("FAIL bp_latency got %0d want 11", n); end
      checks++; if (bus.R !== 11'd8) begin errors++; $display("FAIL bp_R2 got %0d want 8", bus.R); end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      prev_r = 8;
   endtask

   task automatic test_abort();
      int r, lat;
      bit ok;
      abort = 1'b1; bus.in_valid = 1'b1; bus.X = 400'd1;
      step();
      abort = 1'b0; bus.in_valid = 1'b0;
      checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL abort_idle got busy=%b rdy=%b want 0/1", busy, bus.in_ready);
      end
      bus.in_valid = 1'b1; bus.X = '1;
      step();
      bus.in_valid = 1'b0;
      repeat (4) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL abort_run got busy=%b v=%b rdy=%b want 0/0/1", busy, bus.out_valid, bus.in_ready);
      end
      checks++; if (int'(bus.R) != prev_r) begin errors++; $display("FAIL abort_R_kept got %0d want %0d", bus.R, prev_r); end
      run_op(400'd2012, r, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL abort_next_timeout got none want out_valid"); end
      checks++; if (r != 1) begin errors++; $display("FAIL abort_next_R got %0d want 1", r); end
      checks++; if (lat != 11) begin errors++; $display("FAIL abort_next_latency got %0d want 11", lat); end
      prev_r = 1;
   endtask

   task automatic test_async_rst();
      bus.in_valid = 1'b1; bus.X = '1;
      step();
      bus.in_valid = 1'b0;
      step(); step();
      #2 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.R !== 11'd0) begin
         errors++; $display("FAIL arst_immediate got busy=%b rdy=%b v=%b R=%0d want 0/1/0/0", busy, bus.in_ready, bus.out_valid, bus.R);
      end
      @(negedge clk);
      #2 rst = 1'b0;
      for (int c = 0; c < 15; c++) begin
         step();
         checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL arst_stale c=%0d got v=%b busy=%b want 0/0", c, bus.out_valid, busy);
         end
      end
      prev_r = 0;
   endtask

   task automatic test_back_to_back();
      logic [415:0] tmp;
      logic [IN_W:1] x;
      int r, lat, exp_r;
      bit ok;
      for (int n = 0; n < 1000; n++) begin
         for (int w = 0; w < 13; w++) tmp[w*32 +: 32] = $urandom();
         x = tmp[399:0];
         exp_r = ref_mod(x);
         run_op(x, r, lat, ok);
         checks++; if (!ok || r != exp_r || lat != 11) begin
            errors++; $display("FAIL stream%0d got ok=%0d R=%0d lat=%0d want 1/%0d/11", n, ok, r, lat, exp_r);
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_vectors();
      test_backpressure();
      test_abort();
      test_async_rst();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
